irq_encoder: RTL and testbench

Registered priority encoder that turns a multi-hot interrupt request vector into a single granted index with a valid/ready handshake. It is the encode-side counterpart of the CPU's index-to-one-hot decoders. It sits between the interrupt sources / ESTAT logic and the exception unit, which consumes one index per handshake. Requests are latched as sticky pending bits and cleared only when their index is accepted.

---
 rtl/irq_encoder_pkg.sv | 13 +
 rtl/irq_encoder_prio_enc_n.sv | 23 ++
 rtl/irq_encoder.sv | 129 ++++++++++++
 tb/tb_irq_encoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_encoder_pkg.sv
// Shared definitions for the interrupt encoder: default sizing and FSM state encodings.
// Also consumed by the exception unit, so keep encodings stable.
package irq_encoder_pkg;

    localparam int IRQ_N_DEF  = 32;
    localparam int IRQ_IW_DEF = 5;

    typedef logic [0:0] irq_state_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

endpackage

// File: rtl/irq_encoder_prio_enc_n.sv
// Combinational N-to-IW highest-set-bit encoder with an any-bit flag.
module prio_enc_n #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/irq_encoder.sv
// Registered interrupt priority encoder with sticky pending bits and valid/ready output.
// Define LACPU_IRQ_RR_EN for round-robin arbitration; default is fixed highest-index priority.
module irq_encoder
    import irq_encoder_pkg::*;
#(
    parameter int N  = IRQ_N_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  irq_in,
    input  logic [N-1:0]  irq_mask,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    input  logic          out_ready,
    output logic [N-1:0]  pending_o
);

    irq_state_t    r_state;
    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_pending;

    logic          w_hs;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_cand;
    logic [IW-1:0] w_next_idx;
    logic          w_any;

    assign w_hs = r_valid && out_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_clr
        assign w_clr[gi] = w_hs && (r_idx == IW'(gi));
    end

    // The bit being granted this cycle is excluded so back-to-back grants move on.
    assign w_cand = r_pending & irq_mask & ~w_clr;

`ifdef LACPU_IRQ_RR_EN
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_eff;
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_enc_rot;
    logic [IW:0]   w_sum;

    // On a handshake the pointer is about to become the granted index; search from it now.
    assign w_ptr_eff = w_hs ? r_idx : r_ptr;

    // Rotate so that cand[ptr-1] lands at the top and cand[ptr] at bit 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0]   w_pos;
        logic [IW-1:0] w_src;
        assign w_pos = (IW+1)'(gi) + {1'b0, w_ptr_eff};
        assign w_src = (w_pos >= N_W) ? IW'(w_pos - N_W) : IW'(w_pos);
        assign w_rot[gi] = w_cand[w_src];
    end

    prio_enc_n #(
        .N  (N),
        .IW (IW)
    ) u_prio_enc (
        .i_vec (w_rot),
        .o_idx (w_enc_rot),
        .o_any (w_any)
    );

    assign w_sum      = {1'b0, w_enc_rot} + {1'b0, w_ptr_eff};
    assign w_next_idx = (w_sum >= N_W) ? IW'(w_sum - N_W) : IW'(w_sum);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= r_idx;
        end
    end
`else
    prio_enc_n #(
        .N  (N),
        .IW (IW)
    ) u_prio_enc (
        .i_vec (w_cand),
        .o_idx (w_next_idx),
        .o_any (w_any)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_pending <= '0;
        end else begin
            // Set wins over clear when the granted line re-requests in the same cycle.
            r_pending <= (r_pending & ~w_clr) | irq_in;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_next_idx;
                        r_valid <= 1'b1;
                        r_state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_hs) begin
                        if (w_any) begin
                            r_idx <= w_next_idx;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pending_o = r_pending;

endmodule

// File: tb/tb_irq_encoder.sv
// Scoreboard bench for irq_encoder: expected grants are queued and popped on each handshake.
module tb_irq_encoder;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic [N-1:0]  irq_mask;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_ready;
    logic [N-1:0]  pending_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    irq_encoder #(
        .N  (N),
        .IW (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending_o (pending_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; a handshake seen before the edge pops and checks the scoreboard.
    task automatic tick();
        logic          hs;
        logic [IW-1:0] idx;
        int            e;
        hs  = out_valid && out_ready && !reset;
        idx = out_idx;
        @(posedge clk);
        #1;
        if (hs) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("grant idx=%0d expected=%0d", idx, e);
                check("grant_idx", 32'(idx), 32'(e));
            end
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            tick();
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        irq_in    = '0;
        irq_mask  = '1;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pending", pending_o, 32'd0);

        // Single pulse on line 4: two-cycle latency, cleared after grant.
        irq_in    = 32'h0000_0010;
        out_ready = 1'b1;
        tick();
        irq_in = '0;
        check("t1_pend_c1", pending_o, 32'h0000_0010);
        check("t1_valid_c1", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_c2", 32'(out_valid), 32'd1);
        check("t1_idx_c2", 32'(out_idx), 32'd4);
        exp_q.push_back(4);
        tick();
        check("t1_pend_c3", pending_o, 32'd0);
        check("t1_valid_c3", 32'(out_valid), 32'd0);

        // Three lines at once: back-to-back grants highest first.
        do_reset();
        irq_in    = 32'h0000_1005;
        out_ready = 1'b1;
        tick();
        irq_in = '0;
        tick();
        check("t2_valid_c2", 32'(out_valid), 32'd1);
        check("t2_idx_c2", 32'(out_idx), 32'd12);
        exp_q.push_back(12);
        exp_q.push_back(2);
        exp_q.push_back(0);
        tick();
        check("t2_idx_c3", 32'(out_idx), 32'd2);
        tick();
        check("t2_idx_c4", 32'(out_idx), 32'd0);
        tick();
        check("t2_valid_c5", 32'(out_valid), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Presented index is held while ready is low, even with a higher request arriving.
        do_reset();
        irq_in = 32'h0000_0080;
        tick();
        irq_in = '0;
        tick();
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_idx", 32'(out_idx), 32'd7);
        irq_in = 32'h0010_0000;
        tick();
        irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold", 32'(out_idx), 32'd7);
        end
        check("t3_pend", pending_o, 32'h0010_0080);
        out_ready = 1'b1;
        exp_q.push_back(7);
        exp_q.push_back(20);
        tick();
        check("t3_next_valid", 32'(out_valid), 32'd1);
        check("t3_next_idx", 32'(out_idx), 32'd20);
        tick();
        check("t3_done_valid", 32'(out_valid), 32'd0);

        // Masked line stays pending until unmasked.
        do_reset();
        irq_mask  = ~32'h0000_0008;
        out_ready = 1'b1;
        irq_in    = 32'h0000_0008;
        tick();
        irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("t4_masked_valid", 32'(out_valid), 32'd0);
        check("t4_masked_pend3", 32'(pending_o[3]), 32'd1);
        irq_mask = '1;
        tick();
        check("t4_unmask_valid", 32'(out_valid), 32'd1);
        check("t4_unmask_idx", 32'(out_idx), 32'd3);
        exp_q.push_back(3);
        tick();
        check("t4_pend_clr", pending_o, 32'd0);

        // Re-request on the granted line in the handshake cycle: set wins, granted again.
        do_reset();
        irq_in = 32'h0000_0020;
        tick();
        irq_in = '0;
        tick();
        check("t5_idx", 32'(out_idx), 32'd5);
        irq_in    = 32'h0000_0020;
        out_ready = 1'b1;
        exp_q.push_back(5);
        tick();
        irq_in = '0;
        check("t5_pend5_kept", 32'(pending_o[5]), 32'd1);
        exp_q.push_back(5);
        drain(6);
        check("t5_pend_final", pending_o, 32'd0);
        check("t5_valid_final", 32'(out_valid), 32'd0);

        // Lines 1..3 held high: arbitration order, then reset mid-handshake.
        do_reset();
        out_ready = 1'b1;
        irq_in    = 32'h0000_000E;
`ifdef LACPU_IRQ_RR_EN
        exp_q = '{3, 2, 1, 3, 2, 1};
`else
        exp_q = '{3, 2, 3, 2, 3, 2};
`endif
        drain(12);
        check("t6_busy", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_pend", pending_o, 32'd0);
        check("t6_rst_idx", 32'(out_idx), 32'd0);
        reset  = 1'b0;
        irq_in = '0;
        tick();
        check("t6_post_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
